uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: the receive half of the uart block, paired with uart_tx.
//  It oversamples the serial line using the shared 16x baud tick (s_tick).
//  It detects the start bit, samples each data bit at mid-bit (LSB first),
//  checks the stop bit, and presents a parallel word with a one-clock done pulse.
//  It sits between the pad (rx) and the FIFO or host logic that consumes received bytes.
// PARAMETERS
//  DBIT     8   data bits per frame, 5..8
//  SB_TICK  16  s_ticks spent in stop state: 16/24/32 = 1/1.5/2 stop bits
// PORTS
//  clk           in   1     system clock
//  rst           in   1     reset, asynchronous, active-high
//  rx            in   1     serial line, idle high, asynchronous to clk
//  s_tick        in   1     16x-baud enable pulse, one clk wide
//  dout          out  DBIT  last received word, held until next frame completes
//  rx_done_tick  out  1     one-clk pulse: dout/frame_err updated
//  frame_err     out  1     stop bit sampled low on last frame; held like dout
// BEHAVIOUR
//  Reset: state=idle, all counters 0, shift reg 0, sync FFs=1;
//   dout=0, rx_done_tick=0, frame_err=0.
//  Reset mid-frame: abort to idle; no rx_done_tick; dout keeps reset value 0.
//  Sync: rx passes through a 2-FF synchronizer (reset to 1) -> rx_s.
//   FSM uses rx_s only (+2 clk latency).
//  Regs: tk (5b tick count), n (3b bit idx), b (DBIT shift reg).
//   Registered next-state FSM; all outputs registered.
//  States:
//   idle : if rx_s==0 -> start, tk=0. s_tick ignored.
//   start: on s_tick: if tk==7 (mid start bit):
//            rx_s==0 -> data, tk=0, n=0
//            rx_s==1 -> idle (glitch reject, no pulse)
//          else tk++.
//   data : on s_tick: if tk==15:
//            tk=0, b={rx_s, b[DBIT-1:1]}
//            if n==DBIT-1 -> stop, else n++
//          else tk++.
//   stop : on s_tick: if tk==SB_TICK-1:
//            -> idle, dout<=b, frame_err<=~rx_s, rx_done_tick<=1
//          else tk++.
//  rx_done_tick is high for exactly the one clk after the final stop sample.
//   It is 0 in every other cycle.
//  Frame is returned to idle after mid-stop sample (SB_TICK/16 bit after last
//   data mid); a start edge immediately following is accepted (back-to-back).
//  Framing error: word still delivered with pulse; frame_err=1. If rx stays
//   low (break), FSM re-enters start and rejects/accepts per normal rules.
//  No s_tick: counters and state hold (except idle->start on rx_s low).
//  tk never exceeds SB_TICK-1 (max 31); n wraps only via state exit.
// TESTING
//  Clock 100 MHz, s_tick every 54 clk (115200 baud x16); drive rx from uart_tx
//   or a bit-accurate model.
//  1 Frame 0xA5, 1 stop -> one rx_done_tick, dout=8'hA5, frame_err=0.
//  2 Back-to-back 0x00 then 0xFF, no idle gap -> two pulses;
//    dout=8'h00 then 8'hFF; frame_err=0 both.
//  3 rx low pulse of 4 s_ticks then high -> returns to idle, no rx_done_tick,
//    dout unchanged.
//  4 Frame 0x3C with stop bit driven low -> pulse, dout=8'h3C, frame_err=1.
//    Next clean 0x55 -> frame_err=0.
//  5 Assert rst during data bit 3 of 0x81 -> outputs 0 immediately, no pulse.
//    Following 0x81 frame received correctly.
//  6 DBIT=7, SB_TICK=32, frame 7'h5A -> pulse 32 s_ticks after last data mid,
//    dout=7'h5A.

Source files
------------

// File: rtl/uart_rx_if.sv
// Purpose: bundle of the uart_rx receive-side signals.
//   rx, s_tick            : serial line and 16x baud enable coming into the receiver
//   dout, rx_done_tick,
//   frame_err             : received word, its one-clock strobe and stop-bit status
// Handshake: rx_done_tick is a qualifier strobe with no backpressure. dout and
//   frame_err are valid in the cycle rx_done_tick is high, and they stay stable until
//   the next strobe. A consumer that cannot take the word in that cycle must latch it.
// Modports: master = receiver (produces the word), slave = pad/tick source plus consumer.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (
    input  rx,
    input  s_tick,
    output dout,
    output rx_done_tick,
    output frame_err
  );

  modport slave (
    output rx,
    output s_tick,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Purpose: UART receiver. It oversamples rx with the shared 16x baud tick, finds the
//   start bit, samples each data bit at mid-bit (LSB first), checks the stop bit and
//   presents the word with a one-clock rx_done_tick.
// Ports:
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   rx_if    : uart_rx_if.master (rx, s_tick in; dout, rx_done_tick, frame_err out)
//   state_o  : current FSM state (0 idle, 1 start, 2 data, 3 stop)
// Parameters: DBIT data bits (5..8), SB_TICK s_ticks in stop (16/24/32).
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_if.master   rx_if,
  output logic [1:0]  state_o
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [4:0] TK_MID  = 5'd7;
  localparam logic [4:0] TK_BIT  = 5'd15;
  localparam logic [4:0] TK_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  logic            rx_meta_q, rx_s_q;
  logic [1:0]      state_q, state_d;
  logic [4:0]      tk_q, tk_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  // The synchronizer resets to 1 (line idle), so a reset cannot look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          tk_d    = 5'd0;
        end
      end
      ST_START: begin
        if (rx_if.s_tick) begin
          if (tk_q == TK_MID) begin
            // At mid start bit, a high line means the low level was a glitch.
            if (!rx_s_q) begin
              state_d = ST_DATA;
              tk_d    = 5'd0;
              n_d     = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (rx_if.s_tick) begin
          if (tk_q == TK_BIT) begin
            tk_d = 5'd0;
            b_d  = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (rx_if.s_tick) begin
          if (tk_q == TK_STOP) begin
            state_d = ST_IDLE;
            dout_d  = b_q;
            err_d   = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tk_q    <= 5'd0;
      n_q     <= 3'd0;
      b_q     <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rx_if.dout         = dout_q;
  assign rx_if.frame_err    = err_q;
  assign rx_if.rx_done_tick = done_q;
  assign state_o            = state_q;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // The free-running 16x tick is one clk wide, every 54 clocks.
  int unsigned div_cnt = 0;
  logic        s_tick  = 1'b0;
  always @(posedge clk) begin
    div_cnt <= (div_cnt == 53) ? 0 : div_cnt + 1;
    s_tick  <= (div_cnt == 53);
  end

  uart_rx_if #(.DBIT(8)) if8 ();
  uart_rx_if #(.DBIT(7)) if7 ();
  assign if8.s_tick = s_tick;
  assign if7.s_tick = s_tick;

  logic [1:0] state8, state7;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .rst(rst), .rx_if(if8), .state_o(state8)
  );
  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .rst(rst), .rx_if(if7), .state_o(state7)
  );

  // scoreboard entries are {frame_err, word}
  logic [8:0] exp_q[$];
  logic [7:0] exp7_q[$];
  logic [8:0] mon_e8;
  logic [7:0] mon_e7;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (if8.rx_done_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse8: got dout=%h err=%b, required no pulse",
                 if8.dout, if8.frame_err);
      end else begin
        mon_e8 = exp_q.pop_front();
        if ({if8.frame_err, if8.dout} !== mon_e8) begin
          errors++;
          $display("FAIL word8: got err=%b dout=%h, required err=%b dout=%h",
                   if8.frame_err, if8.dout, mon_e8[8], mon_e8[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if7.rx_done_tick === 1'b1) begin
      checks++;
      if (exp7_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse7: got dout=%h err=%b, required no pulse",
                 if7.dout, if7.frame_err);
      end else begin
        mon_e7 = exp7_q.pop_front();
        if ({if7.frame_err, if7.dout} !== mon_e7) begin
          errors++;
          $display("FAIL word7: got err=%b dout=%h, required err=%b dout=%h",
                   if7.frame_err, if7.dout, mon_e7[7], mon_e7[6:0]);
        end
      end
    end
  end

  // Ends at the negedge where the n-th tick is pending (the DUT consumes it at the next posedge).
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!s_tick) @(negedge clk);
    end
  endtask

  task automatic send_bit8(input logic b, input int ticks);
    if8.rx = b;
    wait_ticks(ticks);
  endtask

  task automatic send_frame8(input logic [7:0] d, input bit stop_ok);
    exp_q.push_back({~stop_ok, d});
    send_bit8(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit8(d[i], 16);
    if (stop_ok) begin
      send_bit8(1'b1, 16);
    end else begin
      // Low through the mid-stop sample, then released so the line returns to idle.
      send_bit8(1'b0, 10);
      send_bit8(1'b1, 6);
    end
  endtask

  task automatic check_drained8(input string name);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulses still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    if8.rx = 1'b1;
    if7.rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if8.dout, if8.frame_err, if8.rx_done_tick, state8} !== 13'd0) begin
      errors++;
      $display("FAIL reset8: got dout=%h err=%b done=%b state=%0d, required all 0",
               if8.dout, if8.frame_err, if8.rx_done_tick, state8);
    end
    checks++;
    if ({if7.dout, if7.frame_err, if7.rx_done_tick, state7} !== 12'd0) begin
      errors++;
      $display("FAIL reset7: got dout=%h err=%b done=%b state=%0d, required all 0",
               if7.dout, if7.frame_err, if7.rx_done_tick, state7);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame();
    send_frame8(8'hA5, 1'b1);
    check_drained8("frame_a5_pulse");
    checks++;
    if (if8.dout !== 8'hA5 || if8.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_a5_hold: got dout=%h err=%b, required a5 0", if8.dout, if8.frame_err);
    end
  endtask

  task automatic test_dbit7();
    int  cnt;
    bit  seen;
    logic [6:0] d;
    d    = 7'h5A;
    cnt  = 0;
    seen = 0;
    exp7_q.push_back({1'b0, d});
    if7.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 6; i++) begin
      if7.rx = d[i];
      wait_ticks(16);
    end
    if7.rx = d[6];
    wait_ticks(8);
    // The pulse must follow exactly SB_TICK ticks after the last data mid-sample.
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (k == 0 || cnt > 0 || s_tick) if7.rx = 1'b1;
      if (s_tick) cnt++;
      if (if7.rx_done_tick === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cnt != 32) begin
      errors++;
      $display("FAIL dbit7_stop_timing: got seen=%0d ticks=%0d, required seen=1 ticks=32", seen, cnt);
    end
    wait_ticks(8);
    checks++;
    if (exp7_q.size() != 0 || if7.dout !== 7'h5A) begin
      errors++;
      $display("FAIL dbit7_word: got pending=%0d dout=%h, required 0 5a", exp7_q.size(), if7.dout);
      exp7_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    send_frame8(8'h00, 1'b1);
    send_frame8(8'hFF, 1'b1);
    check_drained8("b2b_pulses");
    checks++;
    if (if8.dout !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_last: got dout=%h, required ff", if8.dout);
    end
  endtask

  task automatic test_glitch();
    send_bit8(1'b0, 4);
    send_bit8(1'b1, 32);
    checks++;
    if (state8 !== 2'd0) begin
      errors++;
      $display("FAIL glitch_idle: got state=%0d, required 0", state8);
    end
    checks++;
    if (if8.dout !== 8'hFF || if8.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_hold: got dout=%h err=%b, required ff 0", if8.dout, if8.frame_err);
    end
    check_drained8("glitch_no_pulse");
  endtask

  task automatic test_frame_error();
    send_frame8(8'h3C, 1'b0);
    check_drained8("ferr_pulse");
    checks++;
    if (if8.dout !== 8'h3C || if8.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_hold: got dout=%h err=%b, required 3c 1", if8.dout, if8.frame_err);
    end
    send_bit8(1'b1, 16);
    send_frame8(8'h55, 1'b1);
    check_drained8("clean_after_ferr");
    checks++;
    if (if8.dout !== 8'h55 || if8.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_clear: got dout=%h err=%b, required 55 0", if8.dout, if8.frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h81;
    send_bit8(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit8(d[i], 16);
    send_bit8(d[3], 8);
    rst = 1'b1;
    #1;
    checks++;
    if ({if8.dout, if8.frame_err, if8.rx_done_tick, state8} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid: got dout=%h err=%b done=%b state=%0d, required all 0",
               if8.dout, if8.frame_err, if8.rx_done_tick, state8);
    end
    if8.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bit8(1'b1, 16);
    checks++;
    if (if8.dout !== 8'h00 || state8 !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_hold: got dout=%h state=%0d, required 00 0", if8.dout, state8);
    end
    send_frame8(d, 1'b1);
    check_drained8("after_reset_pulse");
    checks++;
    if (if8.dout !== 8'h81) begin
      errors++;
      $display("FAIL after_reset_word: got dout=%h, required 81", if8.dout);
    end
  endtask

  initial begin
    test_reset();
    fork
      test_single_frame();
      test_dbit7();
    join
    send_bit8(1'b1, 16);
    test_back_to_back();
    test_glitch();
    test_frame_error();
    send_bit8(1'b1, 16);
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
